// File: rtl/trng_vn_sampler.sv
// trng_vn_sampler: synchronises a free-running ring-oscillator bit, samples it at a
// programmable rate, Von Neumann debiases it, packs words and runs a repetition-count test.
//
// state    | meaning
// ST_FIRST | waiting for the first sample of a pair
// ST_PAIR  | b0 held; next strobe emits b0 if the samples differ
module trng_vn_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8,
  parameter int WORD_W      = 8,
  parameter int REP_LIMIT   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              raw_in,
  input  logic [DIV_W-1:0]  div,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rep_fail,
  output logic              overrun
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);

  typedef enum logic {ST_FIRST = 1'b0, ST_PAIR = 1'b1} vn_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DIV_W-1:0]       div_cnt;
  logic                   strobe;
  vn_state_t              state_q, state_d;
  logic                   b0_q;
  logic                   emit, latch_b0;
  logic [WORD_W-1:0]      acc_q, acc_next, load_word;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   full, completes, slot_free, load;
  logic [RUN_W-1:0]       run_q, run_d;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // counter above a freshly lowered div wraps to 0 without a strobe
  assign strobe = ena && (div_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   div_cnt <= '0;
    else if (!ena || div_cnt >= div) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FIRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = ST_FIRST;
    end else if (strobe) begin
      case (state_q)
        ST_FIRST: state_d = ST_PAIR;
        ST_PAIR:  state_d = ST_FIRST;
        default:  state_d = ST_FIRST;
      endcase
    end
  end

  always_comb begin
    emit     = 1'b0;
    latch_b0 = 1'b0;
    if (strobe) begin
      if (state_q == ST_FIRST) latch_b0 = 1'b1;
      else if (s != b0_q)      emit     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        b0_q <= 1'b0;
    else if (!ena)     b0_q <= 1'b0;
    else if (latch_b0) b0_q <= s;
  end

  assign full      = (bit_cnt == CNT_FULL);
  assign acc_next  = {acc_q[WORD_W-2:0], b0_q};
  assign completes = emit && !full && (bit_cnt == CNT_FULL - 1'b1);
  assign slot_free = !out_valid || out_ready;
  assign load      = ena && slot_free && (full || completes);
  assign load_word = full ? acc_q : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      bit_cnt <= '0;
    end else if (!ena || load) begin
      acc_q   <= '0;
      bit_cnt <= '0;
    end else if (emit && !full) begin
      acc_q   <= acc_next;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          overrun <= 1'b0;
    else if (emit && full) overrun <= 1'b1;
  end

  always_comb begin
    run_d = run_q;
    if (run_q == '0 || s != prev_q) run_d = RUN_W'(1);
    else if (run_q != RUN_MAX)      run_d = run_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= '0;
      prev_q   <= 1'b0;
      rep_fail <= 1'b0;
    end else if (!ena) begin
      run_q <= '0;
    end else if (strobe) begin
      run_q  <= run_d;
      prev_q <= s;
      if (run_d == RUN_MAX) rep_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_vn_sampler.sv
// Bench for trng_vn_sampler: queue-based reference model checked every cycle, a table of
// raw-bit vectors, and directed sequences for backpressure, reset, health and divider.
module tb_trng_vn_sampler;

  localparam int W   = 8;
  localparam int LIM = 32;
  localparam int SYN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       raw_in = 1'b0;
  logic [7:0] div = 8'd0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       rep_fail;
  logic       overrun;

  trng_vn_sampler #(.SYNC_STAGES(SYN), .DIV_W(8), .WORD_W(W), .REP_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in), .div(div),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rep_fail(rep_fail), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: raw delay line, pair logic and bit queue
  bit         raw_q[$];
  int         phase;
  bit         have_first, b0m;
  bit         acc_m[$];
  bit         ov_m, ovr_m, rf_m, prev_m;
  logic [7:0] od_m;
  int         run_m;

  function automatic logic [7:0] pack_acc();
    logic [7:0] w = '0;
    foreach (acc_m[i]) w = {w[6:0], acc_m[i]};
    return w;
  endfunction

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < SYN; i++) raw_q.push_back(1'b0);
    phase = 0; have_first = 0; b0m = 0; acc_m.delete();
    ov_m = 0; ovr_m = 0; rf_m = 0; prev_m = 0; od_m = '0; run_m = 0;
  endtask

  task automatic model_step();
    bit s, strobe, emit, ebit, accept, free, loaded;
    s = raw_q[0];
    void'(raw_q.pop_front());
    raw_q.push_back(raw_in);
    strobe = ena && (phase == int'(div));
    phase  = (!ena || phase >= int'(div)) ? 0 : phase + 1;
    accept = ov_m && out_ready;
    free   = !ov_m || out_ready;
    emit = 0; ebit = 0; loaded = 0;
    if (!ena) have_first = 0;
    else if (strobe) begin
      if (!have_first) begin b0m = s; have_first = 1; end
      else begin emit = (s != b0m); ebit = b0m; have_first = 0; end
    end
    if (!ena) acc_m.delete();
    else if (acc_m.size() == W) begin
      if (emit) ovr_m = 1;
      if (free) begin od_m = pack_acc(); loaded = 1; acc_m.delete(); end
    end else if (emit) begin
      acc_m.push_back(ebit);
      if (acc_m.size() == W && free) begin od_m = pack_acc(); loaded = 1; acc_m.delete(); end
    end
    if (loaded) ov_m = 1;
    else if (accept) ov_m = 0;
    if (!ena) run_m = 0;
    else if (strobe) begin
      if (run_m == 0 || s != prev_m) run_m = 1;
      else if (run_m < LIM) run_m++;
      prev_m = s;
      if (run_m == LIM) rf_m = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("lk_valid",   32'(out_valid), 32'(ov_m));
      check("lk_data",    32'(out_data),  32'(od_m));
      check("lk_repfail", 32'(rep_fail),  32'(rf_m));
      check("lk_overrun", 32'(overrun),   32'(ovr_m));
    end
  end

  logic       ov_log [0:79];
  logic [7:0] od_log [0:79];

  task automatic do_reset();
    ena = 1'b0; out_ready = 1'b0; raw_in = 1'b0;
    @(negedge clk); #3 rst_n = 1'b0;
    @(negedge clk); #3 rst_n = 1'b1;
  endtask

  // raw bit k is driven at negedge k; ena rises once the synchroniser holds bit 0
  task automatic run_raw(input logic [63:0] bits, input int n, input int rdy_from,
                         input int rdy_to, input bit keep_ena);
    for (int k = 0; k < n + 5; k++) begin
      @(negedge clk);
      ov_log[k] = out_valid;
      od_log[k] = out_data;
      raw_in    = (k < n) ? bits[n-1-k] : 1'b0;
      ena       = keep_ena ? (k >= 2) : (k >= 2 && k < n + 2);
      out_ready = (k >= rdy_from && k < rdy_to);
    end
  endtask

  function automatic logic [63:0] vn_encode(input logic [23:0] bits, input int nbits);
    logic [63:0] r = '0;
    for (int i = nbits - 1; i >= 0; i--) r = {r[61:0], bits[i], ~bits[i]};
    return r;
  endfunction

  typedef struct {
    logic [31:0] raw;
    int          n_words;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          k0;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, nw, first_k, wi;
    bit anyv, held;
    logic [7:0] words [2];
    int bias;

    vecs[0] = '{32'h63636363, 1, 8'h55, 8'h00, 30};
    vecs[1] = '{32'hAAAAAAAA, 2, 8'hFF, 8'hFF, 18};
    vecs[2] = '{32'h55555555, 2, 8'h00, 8'h00, 18};
    vecs[3] = '{32'h0000FFFF, 0, 8'h00, 8'h00, -1};
    vecs[4] = '{32'h9A590000, 1, 8'hB2, 8'h00, 18};
    vecs[5] = '{32'h66666666, 2, 8'h55, 8'h55, 18};

    do_reset();
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_data",    32'(out_data),  32'd0);
    check("rst_repfail", 32'(rep_fail),  32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);

    div = 8'd0;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_raw({32'h0, vecs[v].raw}, 32, 0, 1000, 1'b0);
      nw = 0; first_k = -1; words[0] = '0; words[1] = '0;
      for (int k = 0; k < 37; k++) begin
        if (ov_log[k]) begin
          if (first_k < 0) first_k = k;
          if (nw < 2) words[nw] = od_log[k];
          nw++;
        end
      end
      check($sformatf("vec%0d_nwords", v), 32'(nw), 32'(vecs[v].n_words));
      check($sformatf("vec%0d_first_cycle", v), 32'(first_k), 32'(vecs[v].k0));
      if (vecs[v].n_words >= 1) check($sformatf("vec%0d_w0", v), 32'(words[0]), 32'(vecs[v].w0));
      if (vecs[v].n_words >= 2) check($sformatf("vec%0d_w1", v), 32'(words[1]), 32'(vecs[v].w1));
    end

    // backpressure: word1 on output, word2 in accumulator, word3 dropped
    do_reset();
    run_raw(vn_encode({8'hC3, 8'h3C, 8'hFF}, 24), 48, 1000, 1000, 1'b1);
    check("bp_not_early", 32'(ov_log[17]), 32'd0);
    check("bp_valid18",   32'(ov_log[18]), 32'd1);
    check("bp_word1",     32'(od_log[18]), 32'hC3);
    held = 1'b1;
    for (int k = 18; k < 53; k++) if (!ov_log[k] || od_log[k] !== 8'hC3) held = 1'b0;
    check("bp_held_stable", 32'(held), 32'd1);
    check("bp_overrun", 32'(overrun), 32'd1);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk);
    check("bp_word2_valid", 32'(out_valid), 32'd1);
    check("bp_word2_data",  32'(out_data),  32'h3C);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0; ena = 1'b0;

    // accept and completion in the same cycle
    do_reset();
    run_raw(vn_encode({8'h00, 8'hA5, 8'h5A}, 16), 32, 33, 1000, 1'b0);
    check("sim_w1_valid",  32'(ov_log[18]), 32'd1);
    check("sim_w1_data",   32'(od_log[18]), 32'hA5);
    check("sim_w1_held",   32'(od_log[33]), 32'hA5);
    check("sim_no_bubble", 32'(ov_log[34]), 32'd1);
    check("sim_w2_data",   32'(od_log[34]), 32'h5A);
    check("sim_done",      32'(ov_log[35]), 32'd0);

    // async reset with a pending word and five bits accumulated
    do_reset();
    run_raw(vn_encode({11'h0, 8'hC3, 5'b10110}, 13), 26, 1000, 1000, 1'b1);
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk); ena = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_data",  32'(out_data),  32'd0);
    check("mr_rf",    32'(rep_fail),  32'd0);
    check("mr_ovr",   32'(overrun),   32'd0);
    @(negedge clk); #3 rst_n = 1'b1;
    anyv = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) anyv = 1'b1;
      raw_in = ~raw_in;
    end
    check("mr_idle_no_valid", 32'(anyv), 32'd0);

    // health: constant raw trips rep_fail after exactly LIM strobes
    do_reset();
    div = 8'd0; raw_in = 1'b1;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    rise = -1; anyv = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rep_fail && rise < 0) rise = k;
      if (out_valid) anyv = 1'b1;
    end
    check("hl_rise_cycle", 32'(rise), 32'd32);
    check("hl_no_words",   32'(anyv), 32'd0);
    for (int k = 0; k < 8; k++) begin @(negedge clk); raw_in = ~raw_in; end
    ena = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    check("hl_sticky", 32'(rep_fail), 32'd1);
    do_reset();
    @(negedge clk);
    check("hl_cleared", 32'(rep_fail), 32'd0);

    // divider: div=3 with raw toggling each cycle makes every strobe see the same value
    div = 8'd3;
    for (int k = 0; k < 4; k++) begin @(negedge clk); raw_in = ~raw_in; end
    ena = 1'b1;
    rise = -1; anyv = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      raw_in = ~raw_in;
      if (k == 64)  check("dv_rf_at64",  32'(rep_fail), 32'd0);
      if (k == 127) check("dv_rf_at127", 32'(rep_fail), 32'd0);
      if (rep_fail && rise < 0) rise = k;
      if (out_valid) anyv = 1'b1;
    end
    check("dv_rise_cycle", 32'(rise), 32'd128);
    check("dv_no_words",   32'(anyv), 32'd0);

    // div lowered below the running count
    do_reset();
    @(negedge clk); div = 8'd9; ena = 1'b1;
    repeat (7) @(negedge clk);
    div = 8'd2;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      raw_in = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // randomized traffic against the model
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      div  = (seg % 5 == 4) ? 8'($urandom_range(4, 12)) : 8'($urandom_range(0, 3));
      bias = (seg % 4 == 3) ? 95 : 50;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        raw_in    = ($urandom_range(0, 99) < bias);
        out_ready = ($urandom_range(0, 3) != 0) && !(seg % 3 == 2 && c < 60);
        ena       = ($urandom_range(0, 63) != 0);
        if ($urandom_range(0, 31) == 0) div = 8'($urandom_range(0, 5));
      end
    end

    wi = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
